// File: rtl/gb_bus_master.sv
// gb_bus_master: timed DMG cartridge bus initiator (setup, strobe, hold) behind a valid/ready port
module gb_bus_master #(
  parameter int SETUP_CLKS  = 2,
  parameter int STROBE_CLKS = 4,
  parameter int HOLD_CLKS   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_adr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic [14:0] adr,
  output logic        n_cs,
  output logic        n_read,
  output logic        n_write,
  output logic [7:0]  data_out,
  output logic        data_oe,
  input  logic [7:0]  data_in
);
  localparam logic [1:0] IDLE = 2'd0, SETUP = 2'd1, STROBE = 2'd2, HOLD = 2'd3;
  // counters are loaded with length-1 so a zero parameter still gives one clock
  localparam logic [7:0] SC = 8'(SETUP_CLKS  == 0 ? 0 : SETUP_CLKS  - 1);
  localparam logic [7:0] TC = 8'(STROBE_CLKS == 0 ? 0 : STROBE_CLKS - 1);
  localparam logic [7:0] HC = 8'(HOLD_CLKS   == 0 ? 0 : HOLD_CLKS   - 1);
  logic [1:0] state;
  logic [7:0] cnt;
  logic       wr;
  always_ff @(posedge clk)
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      wr        <= 1'b0;
      adr       <= '0;
      n_cs      <= 1'b1;
      n_read    <= 1'b1;
      n_write   <= 1'b1;
      data_out  <= '0;
      data_oe   <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      cnt       <= cnt - 8'd1;
      case (state)
        IDLE:
          if (req_valid && req_ready) begin
            state     <= SETUP;
            cnt       <= SC;
            wr        <= req_write;
            adr       <= req_adr[14:0];
            n_cs      <= req_adr[15];
            data_out  <= req_wdata;
            req_ready <= 1'b0;
          end
        SETUP:
          if (cnt == 8'd0) begin
            state   <= STROBE;
            cnt     <= TC;
            n_read  <= wr;
            n_write <= !wr;
            data_oe <= wr;
          end
        STROBE:
          if (cnt == 8'd0) begin
            state     <= HOLD;
            cnt       <= HC;
            n_read    <= 1'b1;
            n_write   <= 1'b1;
            rsp_rdata <= wr ? rsp_rdata : data_in;
          end
        HOLD:
          if (cnt == 8'd0) begin
            state     <= IDLE;
            n_cs      <= 1'b1;
            data_oe   <= 1'b0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b1;
          end
      endcase
    end
endmodule
